// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD <-> binary converter family.
//   state_t   : converter FSM states (IDLE, CONVERT, DONE)
//   DIGIT_W   : bits per packed BCD digit
//   digit_lsb : bit position of digit idx inside a packed BCD vector
//               (digit 0 = least significant digit at bits [3:0])
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int unsigned digit_lsb(input int unsigned idx);
    return idx * DIGIT_W;
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_seq_if
// Request/result bundle of the sequential BCD-to-binary converter.
//   enable   : start request (sampled only while the converter is idle)
//   bcd_in   : NUM_DIGITS packed BCD digits, digit 0 in bits [3:0]
//   data     : binary result, held until the next completion
//   busy     : conversion in progress (CONVERT or DONE)
//   done     : one-cycle pulse, result valid
//   overflow : result did not fit in BIN_WIDTH bits
//   error    : invalid digit seen (only with BCD_DIGIT_CHECK_EN, else 0)
// Modports: master = requester side, slave = converter side.
// ---------------------------------------------------------------------------
interface bcd_to_binary_seq_if
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 11,
  parameter int BIN_WIDTH  = 36
);

  logic                          enable;
  logic [NUM_DIGITS*DIGIT_W-1:0] bcd_in;
  logic [BIN_WIDTH-1:0]          data;
  logic                          busy;
  logic                          done;
  logic                          overflow;
  logic                          error;

  modport master (
    output enable, bcd_in,
    input  data, busy, done, overflow, error
  );

  modport slave (
    input  enable, bcd_in,
    output data, busy, done, overflow, error
  );

endinterface

// File: rtl/bcd_mac10.sv
// ---------------------------------------------------------------------------
// bcd_mac10
// Combinational multiply-by-ten-and-add step: result = acc*10 + digit,
// built as (acc<<3)+(acc<<1) so no multiplier is inferred.
// Optional macro BCD_DIGIT_CHECK_EN adds a digit_valid output (digit <= 9).
//   acc         : running accumulator (ACC_W bits, unsigned)
//   digit       : next BCD digit
//   result      : acc*10 + digit, truncated to ACC_W bits
//   digit_valid : (BCD_DIGIT_CHECK_EN only) digit is a legal decimal digit
// ---------------------------------------------------------------------------
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [ACC_W-1:0]   result
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic               digit_valid
`endif
);

  assign result = (acc << 3) + (acc << 1) + ACC_W'(digit);

`ifdef BCD_DIGIT_CHECK_EN
  assign digit_valid = (digit <= DIGIT_W'(9));
`endif

endmodule

// File: rtl/bcd_to_binary_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_seq
// Sequential BCD-to-binary converter. Consumes one digit per clock, most
// significant first, using acc = acc*10 + digit. A conversion takes
// NUM_DIGITS CONVERT cycles plus one DONE cycle; back-to-back throughput is
// one result per NUM_DIGITS+2 cycles (one IDLE cycle between conversions).
// Optional macro BCD_DIGIT_CHECK_EN: flag digits > 9, force data/overflow
// to 0 and raise error for that result. Without it error is constant 0.
// Ports:
//   Clk   : rising-edge clock
//   Reset : asynchronous active-high reset
//   bus   : bcd_to_binary_seq_if slave (enable, bcd_in, data, busy, done,
//           overflow, error)
// ---------------------------------------------------------------------------
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 11,
  parameter int BIN_WIDTH  = 36
) (
  input  logic                 Clk,
  input  logic                 Reset,
  bcd_to_binary_seq_if.slave   bus
);

  // Four guard bits keep the accumulator exact for any legal configuration;
  // they are what the overflow flag inspects.
  localparam int ACC_W   = BIN_WIDTH + 4;
  localparam int BCD_W   = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MSD_LSB = int'(digit_lsb(NUM_DIGITS - 1));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_t             state_reg;
  state_t             state_next;
  logic [BCD_W-1:0]   shift_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [BIN_WIDTH-1:0] data_reg;
  logic               overflow_reg;

  logic               capture;
  logic               step;
  logic               finish;
  logic               busy;
  logic               done;

  logic [DIGIT_W-1:0] msd;
  logic [ACC_W-1:0]   mac_result;

  // The digit to consume is always at the top of the shift register.
  assign msd = shift_reg[MSD_LSB +: DIGIT_W];

`ifdef BCD_DIGIT_CHECK_EN
  logic digit_valid;
  logic flag_reg;
  logic error_reg;
  logic bad_result;

  // The last digit is checked in the same cycle it is consumed, so it must
  // be folded in combinationally rather than waiting for flag_reg.
  assign bad_result = flag_reg | ~digit_valid;

  bcd_mac10 #(
    .ACC_W (ACC_W)
  ) u_mac (
    .acc         (acc_reg),
    .digit       (msd),
    .result      (mac_result),
    .digit_valid (digit_valid)
  );
`else
  bcd_mac10 #(
    .ACC_W (ACC_W)
  ) u_mac (
    .acc    (acc_reg),
    .digit  (msd),
    .result (mac_result)
  );
`endif

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and control decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.enable) begin
          capture    = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        busy = 1'b1;
        step = 1'b1;
        if (count_reg == LAST_CNT) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: shift register, accumulator, digit counter, result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shift_reg    <= '0;
      acc_reg      <= '0;
      count_reg    <= '0;
      data_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (capture) begin
        shift_reg <= bus.bcd_in;
        acc_reg   <= '0;
        count_reg <= '0;
      end
      if (step) begin
        acc_reg   <= mac_result;
        shift_reg <= shift_reg << DIGIT_W;
        count_reg <= count_reg + CNT_W'(1);
      end
      if (finish) begin
`ifdef BCD_DIGIT_CHECK_EN
        if (bad_result) begin
          data_reg     <= '0;
          overflow_reg <= 1'b0;
        end else begin
          data_reg     <= mac_result[BIN_WIDTH-1:0];
          overflow_reg <= |mac_result[ACC_W-1:BIN_WIDTH];
        end
`else
        data_reg     <= mac_result[BIN_WIDTH-1:0];
        overflow_reg <= |mac_result[ACC_W-1:BIN_WIDTH];
`endif
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  // Sticky invalid-digit flag for the conversion in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flag_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      if (capture) begin
        flag_reg <= 1'b0;
      end else if (step) begin
        flag_reg <= bad_result;
      end
      if (finish) begin
        error_reg <= bad_result;
      end
    end
  end

  assign bus.error = error_reg;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.data     = data_reg;
  assign bus.overflow = overflow_reg;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_binary_seq
// Self-checking bench for bcd_to_binary_seq. Expected results come from a
// decimal reference model and are queued when a request is driven; the
// monitor pops and compares them on every done pulse, including the cycle
// at which done is expected. Honours BCD_DIGIT_CHECK_EN like the design.
// ---------------------------------------------------------------------------
module tb_bcd_to_binary_seq;
  import bcd_pkg::*;

  localparam int N    = 11;
  localparam int BW   = 36;
  localparam int AW   = BW + 4;
  localparam int BCDW = N * DIGIT_W;

  typedef struct {
    logic [BW-1:0] data;
    logic          ovf;
    logic          err;
    int unsigned   cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          spurious = 0;
  exp_t        sb[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  bcd_to_binary_seq_if #(.NUM_DIGITS(N), .BIN_WIDTH(BW)) bus ();

  bcd_to_binary_seq #(.NUM_DIGITS(N), .BIN_WIDTH(BW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  function automatic logic [BCDW-1:0] to_bcd(input longint unsigned v);
    logic [BCDW-1:0] r;
    longint unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference: weighted sum of the raw digit values, MSD first.
  function automatic exp_t model(input logic [BCDW-1:0] b, input int unsigned c);
    exp_t        e;
    logic [AW-1:0] acc;
    logic [3:0]  d;
    bit          bad;
    acc = '0;
    bad = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      d = b[i*4 +: 4];
      if (d > 4'd9) bad = 1'b1;
      acc = acc * AW'(10) + AW'(d);
    end
    e.data = acc[BW-1:0];
    e.ovf  = |acc[AW-1:BW];
    e.err  = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
    if (bad) begin
      e.data = '0;
      e.ovf  = 1'b0;
      e.err  = 1'b1;
    end
`endif
    e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset === 1'b0 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        spurious++;
        $display("unexpected done at cycle %0d data=%0d", cyc, bus.data);
      end else begin
        e = sb.pop_front();
        chk("data", 64'(bus.data), 64'(e.data));
        chk("overflow", 64'(bus.overflow), 64'(e.ovf));
        chk("error", 64'(bus.error), 64'(e.err));
        chk("latency", 64'(cyc), 64'(e.cyc));
        $display("txn cyc=%0d data=%0d ovf=%0b err=%0b (exp data=%0d ovf=%0b err=%0b)",
                 cyc, bus.data, bus.overflow, bus.error, e.data, e.ovf, e.err);
      end
    end
  end

  // Drive one request; the capture edge is the next rising edge.
  task automatic start(input logic [BCDW-1:0] b);
    @(negedge Clk);
    bus.enable = 1'b1;
    bus.bcd_in = b;
    sb.push_back(model(b, cyc + 1 + N));
  endtask

  // Full conversion: scramble bcd_in while busy and measure busy length.
  task automatic run_one(input string tag, input logic [BCDW-1:0] b);
    int busy_cnt;
    busy_cnt = 0;
    start(b);
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (i == 0) begin
        bus.enable = 1'b0;
        bus.bcd_in = BCDW'({$urandom(), $urandom()});
      end
      if (bus.busy === 1'b1) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(N + 1));
    chk({tag, "_drained"}, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BCDW-1:0] b;
    int unsigned     c;

    // Reset state
    Reset      = 1'b1;
    bus.enable = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(negedge Clk);
    chk("rst_data", 64'(bus.data), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_overflow", 64'(bus.overflow), 64'(0));
    chk("rst_error", 64'(bus.error), 64'(0));
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Plain conversion
    run_one("conv_650345768", to_bcd(64'd650345768));

    // Asynchronous reset in the middle of a conversion
    start(to_bcd(64'd650345768));
    @(negedge Clk);
    bus.enable = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("arst_data", 64'(bus.data), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_done", 64'(bus.done), 64'(0));
    chk("arst_overflow", 64'(bus.overflow), 64'(0));
    chk("arst_error", 64'(bus.error), 64'(0));
    sb.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (N + 5) @(negedge Clk);
    chk("no_done_after_reset", 64'(spurious), 64'(0));

    // Full-width value and overflow case
    run_one("conv_56292734539", to_bcd(64'd56292734539));
    run_one("conv_99999999999", to_bcd(64'd99999999999));

    // enable held high: second request starts on the first edge back in IDLE
    @(negedge Clk);
    c = cyc;
    bus.enable = 1'b1;
    bus.bcd_in = to_bcd(64'd1234593);
    sb.push_back(model(to_bcd(64'd1234593), c + 1 + N));
    @(negedge Clk);
    bus.bcd_in = to_bcd(64'd2938710236);
    sb.push_back(model(to_bcd(64'd2938710236), c + 1 + 2 * N + 2));
    for (int i = 0; i < 100 && cyc < c + 2 * N + 4; i++) @(negedge Clk);
    bus.enable = 1'b0;
    repeat (N + 6) @(negedge Clk);
    chk("held_enable_drained", 64'(sb.size()), 64'(0));
    chk("held_enable_no_extra", 64'(spurious), 64'(0));

    // Invalid digit at position 3, then a clean value
    b = to_bcd(64'd1500478987);
    b[15:12] = 4'hA;
    run_one("conv_bad_digit", b);
    run_one("conv_1500478987", to_bcd(64'd1500478987));

    // All zero input still takes the full latency
    run_one("conv_zero", '0);

    repeat (3) @(negedge Clk);
    chk("final_no_spurious", 64'(spurious), 64'(0));
    chk("final_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
